ulpi_reg_arbiter: RTL and testbench

- Multi-channel front end for the ULPI link register port.
- Accepts register read/write requests from NUM_CH independent clients and arbitrates between them round-robin.
- Drives one transaction at a time onto the link's reg_addr/reg_data_write/reg_enable/reg_read_nwrite/reg_done handshake.
- Returns the read data and completion status to the requesting client.
- Sits between the link modport and the controller/debug clients, which share PHY register access.

---
 rtl/ulpi_reg_pkg.sv | 24 ++
 rtl/ulpi_rr_arb.sv | 51 +++++
 rtl/ulpi_reg_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ulpi_reg_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_reg_pkg.sv
// Shared types and constants for the ULPI register-port arbiter.
package ulpi_reg_pkg;

  localparam int ULPI_REG_ADDR_W = 6;
  localparam int ULPI_REG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ULPI_REG_ADDR_W-1:0] addr;
    logic [ULPI_REG_DATA_W-1:0] wdata;
    logic                       read_nwrite;
  } reg_req_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ulpi_rr_arb.sv
// Combinational round-robin pick: first request strictly above ptr, else the lowest request.
module ulpi_rr_arb
  import ulpi_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_grant
);

  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] hi_req;

  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upper[i] = (i > int'(ptr));
    end
  end

  assign hi_req    = req & upper;
  assign any_grant = |req;

  // Scan downward so the lowest set bit of the chosen vector wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (|hi_req) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (hi_req[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin multi-client front end for the ULPI link register port.
// Optional reg_done timeout enabled by defining ULPI_REG_TIMEOUT_EN.
module ulpi_reg_arbiter
  import ulpi_reg_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CH-1:0]                      req_valid,
  output logic [NUM_CH-1:0]                      req_ready,
  input  logic [NUM_CH-1:0][ULPI_REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_CH-1:0][ULPI_REG_DATA_W-1:0] req_wdata,
  input  logic [NUM_CH-1:0]                      req_read_nwrite,
  output logic [NUM_CH-1:0]                      rsp_valid,
  output logic [ULPI_REG_DATA_W-1:0]             rsp_rdata,
  output logic                                   rsp_error,
  output logic [ULPI_REG_ADDR_W-1:0]             reg_addr,
  output logic [ULPI_REG_DATA_W-1:0]             reg_data_write,
  output logic                                   reg_enable,
  output logic                                   reg_read_nwrite,
  input  logic [ULPI_REG_DATA_W-1:0]             reg_data_read,
  input  logic                                   reg_done
);

  localparam int IDX_W = idx_w(NUM_CH);

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           ptr;
  logic [IDX_W-1:0]           ch_q;
  reg_req_t                   req_q;
  logic [ULPI_REG_DATA_W-1:0] rdata_q;

  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_grant;
  logic              accept;
  logic              finish;
  logic              abort;
  logic              expire;

  ulpi_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (any_grant) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // A reg_done coinciding with expiry is still a normal completion.
        if (reg_done) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= IDX_W'(NUM_CH - 1);
      ch_q  <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr   <= grant_idx;
        ch_q  <= grant_idx;
        req_q <= '{addr:        req_addr[grant_idx],
                   wdata:       req_wdata[grant_idx],
                   read_nwrite: req_read_nwrite[grant_idx]};
      end
    end
  end

  // Read data returned to the client; writes and aborts report 0x00.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (finish) begin
      rdata_q <= req_q.read_nwrite ? reg_data_read : '0;
    end else if (abort) begin
      rdata_q <= '0;
    end
  end

`ifdef ULPI_REG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if (state == ISSUE) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (finish) begin
        err_q <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_error = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expire         = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  // The grant pulse is also gated by reset so nothing is accepted while held.
  assign req_ready = ((state == IDLE) && reset_n) ? grant : '0;

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) begin
      rsp_valid[ch_q] = 1'b1;
    end
  end

  assign rsp_rdata       = rdata_q;
  assign reg_enable      = (state == ISSUE);
  assign reg_addr        = req_q.addr;
  assign reg_data_write  = req_q.wdata;
  assign reg_read_nwrite = req_q.read_nwrite;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Scoreboard bench for ulpi_reg_arbiter: random clients and link against a queue-based model.
module tb_ulpi_reg_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][5:0]  req_addr;
  logic [N-1:0][7:0]  req_wdata;
  logic [N-1:0]       req_read_nwrite;
  logic [N-1:0]       rsp_valid;
  logic [7:0]         rsp_rdata;
  logic               rsp_error;
  logic [5:0]         reg_addr;
  logic [7:0]         reg_data_write;
  logic               reg_enable;
  logic               reg_read_nwrite;
  logic [7:0]         reg_data_read;
  logic               reg_done;

  ulpi_reg_arbiter #(
    .NUM_CH         (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_read_nwrite (req_read_nwrite),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .reg_addr        (reg_addr),
    .reg_data_write  (reg_data_write),
    .reg_enable      (reg_enable),
    .reg_read_nwrite (reg_read_nwrite),
    .reg_data_read   (reg_data_read),
    .reg_done        (reg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       rnw;
  } txn_t;

  typedef struct {
    int         ch;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];
  int   grant_log[$];

  int         checks = 0;
  int         failures = 0;
  int         m_ptr = N - 1;
  bit         m_idle = 1'b1;
  logic [N-1:0] acc_mask = '0;
  logic [7:0] last_rdata = 8'h00;
  logic       last_err = 1'b0;
  int         n_rsp = 0;

  bit hang = 1'b0;
  bit spur_en = 1'b0;
  bit rand_en = 1'b0;
  int force_delay = -1;
  int force_data = -1;
  int rep[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check({tag, "_rsp_error"}, 32'(rsp_error), 0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 0);
    check({tag, "_reg_data_write"}, 32'(reg_data_write), 0);
    check({tag, "_reg_enable"}, 32'(reg_enable), 0);
    check({tag, "_reg_read_nwrite"}, 32'(reg_read_nwrite), 0);
  endtask

  // Spec rule: first pending channel searching upward from pointer+1, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic new_fields(input int c);
    req_addr[c]        = 6'($urandom);
    req_wdata[c]       = 8'($urandom);
    req_read_nwrite[c] = 1'($urandom_range(0, 1));
  endtask

  task automatic req(input int c, input logic [5:0] a, input logic [7:0] d, input logic rnw);
    req_addr[c]        = a;
    req_wdata[c]       = d;
    req_read_nwrite[c] = rnw;
    req_valid[c]       = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #3;
      if (req_valid == '0 && txn_q.size() == 0 && rsp_q.size() == 0 && !reg_enable && m_idle) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drain_timeout"}, 32'(ok), 1);
  endtask

  // Monitor: grant prediction and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin : mon
    int           g;
    logic [N-1:0] exp_rdy;
    txn_t         t;
    rsp_t         r;
    if (!reset_n) begin
      m_ptr      = N - 1;
      m_idle     = 1'b1;
      acc_mask   = '0;
      last_rdata = 8'h00;
      last_err   = 1'b0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_idle) g = rr_pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("grant", 32'(req_ready), 32'(exp_rdy));
      acc_mask = exp_rdy;
      if (g >= 0) begin
        t.ch    = g;
        t.addr  = req_addr[g];
        t.wdata = req_wdata[g];
        t.rnw   = req_read_nwrite[g];
        txn_q.push_back(t);
        grant_log.push_back(g);
        m_ptr  = g;
        m_idle = 1'b0;
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_ch", 32'(rsp_valid), 32'(1) << r.ch);
          check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
          check("rsp_error", 32'(rsp_error), 32'(r.err));
          last_rdata = r.rdata;
          last_err   = r.err;
          n_rsp++;
        end
        m_idle = 1'b1;
      end else begin
        check("rsp_hold", 32'(rsp_rdata), 32'(last_rdata));
      end
    end
  end

  // Link model: watches reg_enable and answers with reg_done after a delay.
  initial begin : link
    int   en_cnt;
    int   dly;
    int   cur_ch;
    bit   done_prev;
    int   d;
    txn_t t;
    rsp_t r;
    en_cnt = 0; dly = 0; cur_ch = 0; done_prev = 1'b0;
    reg_done = 1'b0;
    reg_data_read = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        reg_done = 1'b0;
        en_cnt = 0;
        done_prev = 1'b0;
        continue;
      end
      if (acc_mask != '0) check("enable_rise", 32'(reg_enable), 1);
      if (done_prev) begin
        check("enable_fall", 32'(reg_enable), 0);
        check("rsp_timing", 32'(rsp_valid), 32'(1) << cur_ch);
        done_prev = 1'b0;
        en_cnt = 0;
      end
      reg_done = 1'b0;
      reg_data_read = 8'($urandom);
      if (reg_enable) begin
        if (txn_q.size() == 0) begin
          check("enable_spurious", 32'(reg_enable), 0);
        end else begin
          t = txn_q[0];
          if (en_cnt == 0) dly = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
          check("reg_addr", 32'(reg_addr), 32'(t.addr));
          check("reg_data_write", 32'(reg_data_write), 32'(t.wdata));
          check("reg_read_nwrite", 32'(reg_read_nwrite), 32'(t.rnw));
          en_cnt++;
          if (!hang && en_cnt > dly) begin
            d = (force_data >= 0) ? force_data : int'($urandom_range(0, 255));
            reg_done = 1'b1;
            reg_data_read = 8'(d);
            r.ch = t.ch;
            r.rdata = t.rnw ? 8'(d) : 8'h00;
            r.err = 1'b0;
            rsp_q.push_back(r);
            void'(txn_q.pop_front());
            cur_ch = t.ch;
            done_prev = 1'b1;
          end
`ifdef ULPI_REG_TIMEOUT_EN
          else if (hang && en_cnt == TO) begin
            r.ch = t.ch;
            r.rdata = 8'h00;
            r.err = 1'b1;
            rsp_q.push_back(r);
            void'(txn_q.pop_front());
            cur_ch = t.ch;
            done_prev = 1'b1;
          end
`endif
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        reg_done = 1'b1;
      end
    end
  end

  // Client driver: drops or renews accepted requests, random traffic when enabled.
  initial begin : drv
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) continue;
      for (int c = 0; c < N; c++) begin
        if (acc_mask[c]) begin
          if (rep[c] > 0) begin
            rep[c]--;
            new_fields(c);
          end else begin
            req_valid[c] = 1'b0;
          end
        end else if (rand_en) begin
          if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
            new_fields(c);
            req_valid[c] = 1'b1;
          end else if (req_valid[c] && $urandom_range(0, 31) == 0) begin
            req_valid[c] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n_before;
    bit   seen;
    logic [3:0] exp_alt;
    reset_n = 1'b0;
    req_valid = '1;
    req_addr = '0;
    req_wdata = '0;
    req_read_nwrite = '0;
    for (int c = 0; c < N; c++) rep[c] = 0;
    #1;
    check_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");
    req_valid = '0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // ch1 and ch3 together from reset, then ch0 and ch1 together.
    @(posedge clk); #2;
    req(1, 6'h01, 8'h11, 1'b0);
    req(3, 6'h03, 8'h33, 1'b1);
    wait_drain("rr_a");
    @(posedge clk); #2;
    req(0, 6'h04, 8'h44, 1'b1);
    req(1, 6'h05, 8'h55, 1'b0);
    wait_drain("rr_b");
    check("rr_len", 32'(grant_log.size()), 4);
    if (grant_log.size() == 4) begin
      check("rr_0", 32'(grant_log[0]), 1);
      check("rr_1", 32'(grant_log[1]), 3);
      check("rr_2", 32'(grant_log[2]), 0);
      check("rr_3", 32'(grant_log[3]), 1);
    end

    // Write on ch0 with reg_done two cycles after reg_enable.
    grant_log.delete();
    force_delay = 2;
    @(posedge clk); #2;
    req(0, 6'h0A, 8'h55, 1'b0);
    wait_drain("write");
    check("write_grant", 32'(grant_log[0]), 0);
    check("write_rdata", 32'(last_rdata), 0);
    check("write_err", 32'(last_err), 0);

    // Read on ch2 returning 0xA5.
    force_delay = -1;
    force_data = 8'hA5;
    @(posedge clk); #2;
    req(2, 6'h16, 8'h00, 1'b1);
    wait_drain("read");
    check("read_rdata", 32'(last_rdata), 32'hA5);
    force_data = -1;

    // ch0 and ch2 both hold requests for four transactions each.
    grant_log.delete();
    rep[0] = 3;
    rep[2] = 3;
    @(posedge clk); #2;
    req(0, 6'h20, 8'h01, 1'b0);
    req(2, 6'h22, 8'h02, 1'b1);
    wait_drain("alt");
    check("alt_len", 32'(grant_log.size()), 8);
    if (grant_log.size() == 8) begin
      exp_alt = 4'd0;
      for (int i = 0; i < 8; i++) begin
        exp_alt = (i % 2 == 0) ? 4'd0 : 4'd2;
        check("alt_order", 32'(grant_log[i]), 32'(exp_alt));
      end
    end

    // Random traffic with spurious reg_done pulses and withdrawn requests.
    n_before = n_rsp;
    rand_en = 1'b1;
    spur_en = 1'b1;
    repeat (600) @(posedge clk);
    rand_en = 1'b0;
    spur_en = 1'b0;
    wait_drain("random");
    check("random_progress", 32'(n_rsp > n_before + 20), 1);

`ifdef ULPI_REG_TIMEOUT_EN
    hang = 1'b1;
    @(posedge clk); #2;
    req(1, 6'h2A, 8'h00, 1'b1);
    wait_drain("timeout");
    hang = 1'b0;
    check("timeout_err", 32'(last_err), 1);
    check("timeout_rdata", 32'(last_rdata), 0);
    force_data = 8'h3C;
    @(posedge clk); #2;
    req(2, 6'h2B, 8'h00, 1'b1);
    wait_drain("after_timeout");
    force_data = -1;
    check("after_timeout_err", 32'(last_err), 0);
    check("after_timeout_rdata", 32'(last_rdata), 32'h3C);
`endif

    // Reset pulled while the link transaction is outstanding.
    force_delay = 30;
    @(posedge clk); #2;
    req(1, 6'h3F, 8'hC3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (reg_enable) begin
        seen = 1'b1;
        break;
      end
    end
    check("midreset_enable_seen", 32'(seen), 1);
    n_before = n_rsp;
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(posedge clk);
    #2;
    txn_q.delete();
    rsp_q.delete();
    req_valid = '0;
    for (int c = 0; c < N; c++) rep[c] = 0;
    force_delay = -1;
    @(posedge clk);
    #1;
    check_zero("midreset_held");
    #1;
    reset_n = 1'b1;
    check("midreset_no_rsp", 32'(n_rsp), 32'(n_before));

    grant_log.delete();
    force_data = 8'h5A;
    @(posedge clk); #2;
    req(3, 6'h13, 8'h00, 1'b1);
    wait_drain("post_reset");
    force_data = -1;
    check("post_reset_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 3);
    check("post_reset_rsp", 32'(n_rsp), 32'(n_before + 1));
    check("post_reset_rdata", 32'(last_rdata), 32'h5A);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
